// File: rtl/ram_loader_if.sv
// Byte-stream handshake, RAM Address/CE/WE bus and status bundle
// shared by the program-RAM loader and its surroundings.
interface ram_loader_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          Start;
  logic [DW-1:0] DataIn;
  logic          DataValid;
  logic          DataReady;
  logic [AW-1:0] Address;
  logic          CE;
  logic          WE;
  logic [DW-1:0] WData;
  logic [DW-1:0] W;
  logic          Busy;
  logic          Done;
  logic          Fail;
  logic [DW-1:0] Checksum;

  modport master (
    input  Start, DataIn, DataValid, W,
    output DataReady, Address, CE, WE, WData,
    output Busy, Done, Fail, Checksum
  );

  modport slave (
    output Start, DataIn, DataValid, W,
    input  DataReady, Address, CE, WE, WData,
    input  Busy, Done, Fail, Checksum
  );
endinterface

// File: rtl/ram_loader.sv
// Program-RAM writer: streams DEPTH bytes into the RAM, reads them
// back and flags Done/Fail from a mod-2^DW checksum comparison.
module ram_loader #(
  parameter int DEPTH = 16,
  parameter int AW    = 8,
  parameter int DW    = 8
) (
  input  logic          CLK,
  input  logic          CLR,
  ram_loader_if.master  bus
);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WSTB, S_VREAD,
    S_VCHK, S_DONE, S_FAIL
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [PW-1:0] r_ptr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_wsum;
  logic [DW-1:0] r_rsum;
  logic [DW-1:0] r_cksum;
  logic          w_last;
  logic          w_start;

  assign w_last  = (r_ptr == PW'(DEPTH - 1));
  assign w_start = bus.Start &&
                   (r_state == S_IDLE ||
                    r_state == S_DONE ||
                    r_state == S_FAIL);

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE, S_FAIL:
        if (w_start) w_next = S_LOAD;
      S_LOAD:
        if (bus.DataValid) w_next = S_WSTB;
      S_WSTB:
        w_next = w_last ? S_VREAD : S_LOAD;
      S_VREAD:
        if (w_last) w_next = S_VCHK;
      S_VCHK:
        w_next = (r_rsum == r_wsum) ? S_DONE : S_FAIL;
      default:
        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_ptr   <= '0;
      r_wdata <= '0;
      r_wsum  <= '0;
      r_rsum  <= '0;
      r_cksum <= '0;
    end else begin
      if (w_start) begin
        r_ptr  <= '0;
        r_wsum <= '0;
        r_rsum <= '0;
      end
      if (r_state == S_LOAD && bus.DataValid)
        r_wdata <= bus.DataIn;
      if (r_state == S_WSTB) begin
        r_wsum <= r_wsum + r_wdata;
        r_ptr  <= w_last ? '0 : r_ptr + PW'(1);
      end
      // W is sampled at the end of the CE-low cycle
      if (r_state == S_VREAD) begin
        r_rsum <= r_rsum + bus.W;
        if (!w_last) r_ptr <= r_ptr + PW'(1);
      end
      if (r_state == S_VCHK)
        r_cksum <= r_wsum;
    end
  end

  assign bus.Address   = AW'(r_ptr);
  assign bus.WE        = (r_state != S_WSTB);
  assign bus.CE        = (r_state != S_VREAD);
  assign bus.WData     = r_wdata;
  assign bus.DataReady = (r_state == S_LOAD);
  assign bus.Busy      = (r_state == S_LOAD)  ||
                         (r_state == S_WSTB)  ||
                         (r_state == S_VREAD) ||
                         (r_state == S_VCHK);
  assign bus.Done      = (r_state == S_DONE);
  assign bus.Fail      = (r_state == S_FAIL);
  assign bus.Checksum  = r_cksum;
endmodule

// File: tb/tb_ram_loader.sv
// Directed + randomized bench for ram_loader with a behavioural RAM
// and a checksum reference model.
module tb_ram_loader;
  logic CLK = 1'b0;
  logic CLR;
  always #5 CLK = ~CLK;

  ram_loader_if #(.AW(8), .DW(8)) bus ();

  ram_loader #(.DEPTH(16), .AW(8), .DW(8)) dut (
    .CLK(CLK),
    .CLR(CLR),
    .bus(bus)
  );

  logic [7:0] mem [16];
  logic       stuck;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         start_cyc;
  int         we_cnt;
  logic       mon_en  = 1'b0;

  always @(posedge CLK) begin
    cyc++;
    if (!bus.WE) mem[bus.Address[3:0]] <= bus.WData;
  end

  assign bus.W = bus.CE ? 8'h00 :
                 ((stuck && bus.Address == 8'd5) ? 8'h0B
                  : mem[bus.Address[3:0]]);

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  always @(negedge CLK) begin
    if (mon_en && !CLR) begin
      if (!bus.WE) we_cnt++;
      chk("we_ce_both_low", {31'd0, !bus.WE && !bus.CE}, 0);
      chk("ready_outside_load",
          {31'd0, bus.DataReady &&
           !(bus.Busy && bus.WE && bus.CE)}, 0);
      chk("addr_range", {31'd0, bus.Address >= 8'd16}, 0);
    end
  end

  task automatic pulse_start;
    @(negedge CLK);
    bus.Start = 1'b1;
    @(negedge CLK);
    bus.Start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic send_byte(logic [7:0] b, int stalls);
    int t = 0;
    if (stalls > 0) begin
      bus.DataValid = 1'b0;
      repeat (stalls) @(negedge CLK);
    end
    bus.DataIn    = b;
    bus.DataValid = 1'b1;
    while (!bus.DataReady && t < 100) begin
      @(negedge CLK);
      t++;
    end
    chk("ready_timeout", {31'd0, t >= 100}, 0);
    @(negedge CLK);
  endtask

  task automatic wait_done(output int lat);
    int t = 0;
    bus.DataValid = 1'b0;
    while (!(bus.Done || bus.Fail) && t < 200) begin
      @(negedge CLK);
      t++;
    end
    chk("done_timeout", {31'd0, t >= 200}, 0);
    lat = cyc - start_cyc;
  endtask

  task automatic check_result(string tag, logic [7:0] img [16]);
    logic [7:0] wsum = 8'h00;
    logic [7:0] rsum = 8'h00;
    for (int i = 0; i < 16; i++) begin
      wsum += img[i];
      rsum += (stuck && i == 5) ? 8'h0B : img[i];
      chk({tag, "_ram"}, mem[i], img[i]);
    end
    chk({tag, "_cksum"}, bus.Checksum, wsum);
    chk({tag, "_done"}, bus.Done, rsum == wsum);
    chk({tag, "_fail"}, bus.Fail, rsum != wsum);
    chk({tag, "_busy"}, bus.Busy, 0);
  endtask

  task automatic check_reset(string tag);
    chk({tag, "_we"}, bus.WE, 1);
    chk({tag, "_ce"}, bus.CE, 1);
    chk({tag, "_addr"}, bus.Address, 0);
    chk({tag, "_wdata"}, bus.WData, 0);
    chk({tag, "_ready"}, bus.DataReady, 0);
    chk({tag, "_busy"}, bus.Busy, 0);
    chk({tag, "_done"}, bus.Done, 0);
    chk({tag, "_fail"}, bus.Fail, 0);
    chk({tag, "_cksum"}, bus.Checksum, 0);
  endtask

  logic [7:0] img1 [16];
  logic [7:0] img  [16];
  int         lat;

  initial begin
    img1 = '{8'h05, 8'h16, 8'h27, 8'h3F, 8'h4F, 8'h0A,
             8'h0C, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00,
             8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    stuck         = 1'b0;
    bus.Start     = 1'b0;
    bus.DataIn    = 8'h00;
    bus.DataValid = 1'b0;
    CLR           = 1'b1;
    #1;
    check_reset("reset");
    @(negedge CLK);
    CLR    = 1'b0;
    mon_en = 1'b1;

    // Test 1: continuous stream, latency check
    we_cnt = 0;
    pulse_start();
    for (int i = 0; i < 16; i++) send_byte(img1[i], 0);
    wait_done(lat);
    chk("t1_latency", lat, 49);
    check_result("t1", img1);
    chk("t1_we_cycles", we_cnt, 16);

    // Test 2: 3-cycle stall before each byte
    for (int i = 0; i < 16; i++) mem[i] = 8'hEE;
    we_cnt = 0;
    pulse_start();
    for (int i = 0; i < 16; i++) send_byte(img1[i], 3);
    wait_done(lat);
    check_result("t2", img1);
    chk("t2_we_cycles", we_cnt, 16);

    // Test 3: stuck bit at address 5
    stuck = 1'b1;
    pulse_start();
    for (int i = 0; i < 16; i++) send_byte(img1[i], 0);
    wait_done(lat);
    check_result("t3", img1);
    stuck = 1'b0;

    // Test 4: async clear after the 7th byte, then reload
    pulse_start();
    for (int i = 0; i < 7; i++) send_byte(img1[i], 0);
    CLR = 1'b1;
    #1;
    check_reset("t4_clr");
    @(negedge CLK);
    CLR = 1'b0;
    bus.DataValid = 1'b0;
    for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
    pulse_start();
    chk("t4_restart_addr", bus.Address, 0);
    for (int i = 0; i < 16; i++) send_byte(img[i], 0);
    wait_done(lat);
    check_result("t4", img);

    // Test 5: Start in LOAD ignored, Start in DONE restarts
    for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
    pulse_start();
    for (int i = 0; i < 3; i++) send_byte(img[i], 0);
    bus.DataValid = 1'b0;
    bus.Start     = 1'b1;
    repeat (2) @(negedge CLK);
    bus.Start = 1'b0;
    chk("t5_ptr_kept", bus.Address, 3);
    for (int i = 3; i < 16; i++) send_byte(img[i], 0);
    wait_done(lat);
    check_result("t5a", img);
    for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
    pulse_start();
    chk("t5_done_cleared", bus.Done, 0);
    chk("t5_busy", bus.Busy, 1);
    for (int i = 0; i < 16; i++) send_byte(img[i], 0);
    wait_done(lat);
    check_result("t5b", img);

    // Randomized images, stalls and stuck bit
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
      stuck = 1'($urandom);
      pulse_start();
      for (int i = 0; i < 16; i++)
        send_byte(img[i], int'($urandom_range(0, 3)));
      wait_done(lat);
      check_result("rand", img);
    end
    stuck = 1'b0;

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
